lpif_tx_x2_stb_mrk_gen: RTL and testbench
=========================================

LPIF_TX_X2_STB_MRK_GEN -- requirements
Module: lpif_tx_x2_stb_mrk_gen

Interface
REQ-001 SHALL have parameter DWIDTH, default 75, meaning the logic-link data width carried over two 40-bit PHY channels.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of entries in the TX FIFO; power of two, minimum 2.
REQ-003 SHALL have parameter STB_INTERVAL, default 16, meaning the strobe period in clk_wr cycles; minimum 2.
REQ-004 SHALL have port clk_wr, input, width 1, the write-domain clock.
REQ-005 SHALL have port rst_wr_n, input, width 1, the asynchronous active-low reset.
REQ-006 SHALL have port tx_online, input, width 1, link-up qualifier.
REQ-007 SHALL have port in_data, input, width DWIDTH, the logic-link data.
REQ-008 SHALL have port in_valid, input, width 1, data-valid.
REQ-009 SHALL have port in_ready, output, width 1, FIFO can accept.
REQ-010 SHALL have port tx_downstream_pop_ovrd, input, width 1, which stalls FIFO pop when high.
REQ-011 SHALL have port tx_downstream_data, output, width DWIDTH, to the concat stage.
REQ-012 SHALL have port tx_stb_userbit, output, width 1, the strobe bit.
REQ-013 SHALL have port tx_mrk_userbit, output, width 1 ([0:0]), the marker bit.
REQ-014 SHALL have port tx_data_active, output, width 1, high when the current tx_downstream_data beat was popped from the FIFO.

Function
REQ-015 SHALL implement FSM states IDLE, ALIGN and ACTIVE.
REQ-016 SHALL transition IDLE->ALIGN on the first cycle tx_online=1.
REQ-017 SHALL transition ALIGN->ACTIVE in the cycle the first strobe is driven.
REQ-018 SHALL transition from any state to IDLE when tx_online=0, and SHALL flush the FIFO in that same cycle.
REQ-019 SHALL run the strobe counter only in ALIGN/ACTIVE, cleared to 0 on IDLE entry; tx_stb_userbit=1 for one cycle when the counter equals STB_INTERVAL-1, then the counter wraps to 0.
REQ-020 SHALL drive tx_mrk_userbit=1 on every cycle in ALIGN and ACTIVE, and 0 in IDLE.
REQ-021 SHALL drive in_ready = (state!=IDLE) && (count<FIFO_DEPTH); a push occurs when in_valid && in_ready.
REQ-022 SHALL pop only in ACTIVE with count>0 and tx_downstream_pop_ovrd=0.
REQ-023 SHALL register tx_downstream_data and tx_data_active, giving 1-cycle latency from pop to output.
REQ-024 SHALL NOT bypass an empty FIFO; minimum in_data-to-output latency is 2 cycles.
REQ-025 SHALL allow push and pop in the same cycle for count in 1..FIFO_DEPTH-1, leaving count unchanged.
REQ-026 SHALL, on a no-pop cycle, drive tx_data_active=0 and tx_downstream_data=0 (see REQ-032).
REQ-027 SHALL use wrapping pointer arithmetic of width log2(FIFO_DEPTH) and a count of width log2(FIFO_DEPTH)+1.

Reset
REQ-028 SHALL reset asynchronously on rst_wr_n low, with synchronous deassertion assumed externally.
REQ-029 SHALL reset to state IDLE, count 0, pointers 0, strobe counter 0, and all outputs 0 (in_ready=0).
REQ-030 SHALL, on reset mid-transfer, discard FIFO contents with no partial beat output.

Configuration
REQ-031 SHALL use macro LPIF_TX_IDLE_REPEAT_EN to select idle-beat behaviour.
REQ-032 SHALL, with the macro undefined, output zero data on no-pop cycles; with it defined, SHALL hold the last popped data on no-pop cycles (tx_data_active still 0), with the hold register cleared on IDLE entry.

Structure
REQ-033 SHALL place the state enum (IDLE/ALIGN/ACTIVE), DWIDTH default and PHY channel width 40 in package lpif_tx_stb_mrk_pkg.
REQ-034 SHALL implement the FIFO storage/pointers as sub-module lpif_tx_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, full, empty, count).

Verification
REQ-035 SHALL cover: reset, then tx_online=1 at cycle 0 -> ALIGN, tx_mrk_userbit=1 from cycle 1, tx_stb_userbit=1 at cycle 16 only, ACTIVE at cycle 16, next strobe at cycle 32.
REQ-036 SHALL cover: ACTIVE, push 0x1, 0x2, 0x3 on consecutive cycles -> outputs 0x1, 0x2, 0x3 with tx_data_active=1, each 2 cycles after its push.
REQ-037 SHALL cover: ACTIVE, pop_ovrd=1, push 5 beats -> in_ready=0 after 4 beats, 5th held; release pop_ovrd -> all 5 emerge in order.
REQ-038 SHALL cover: FIFO holding 3 entries, tx_online=0 -> IDLE next cycle, count=0, mrk=0, stb=0; re-online -> no stale data.
REQ-039 SHALL cover: rst_wr_n pulsed low mid-stream with 2 entries buffered -> all outputs 0 immediately, FIFO empty.
REQ-040 SHALL cover: LPIF_TX_IDLE_REPEAT_EN defined, pop 0x5A then empty -> data stays 0x5A with tx_data_active=0; undefined -> data 0.

Source files
------------

// File: rtl/lpif_tx_stb_mrk_pkg.sv
// Shared types and constants for the x2 LPIF TX strobe/marker generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lpif_tx_stb_mrk_pkg;

    // Physical side: two 40-bit channels carry one logic-link beat.
    localparam int PHY_CH_WIDTH    = 40;
    localparam int PHY_NUM_CH      = 2;

    // Logic-link payload width that fits beside the per-channel user bits.
    localparam int LPIF_DWIDTH_DEF = 75;

    // Link bring-up sequence: wait for online, align to first strobe, then stream.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/lpif_tx_x2_stb_mrk_gen_if.sv
// Handshake and downstream bus between the logic link and the strobe/marker generator.
// Latency: n/a (wires only).
// Backpressure: in_ready from the generator; tx_downstream_pop_ovrd from downstream.
interface lpif_tx_x2_stb_mrk_gen_if
    import lpif_tx_stb_mrk_pkg::*;
#(
    parameter int DWIDTH = LPIF_DWIDTH_DEF
);
    logic              tx_online;
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tx_downstream_pop_ovrd;
    logic [DWIDTH-1:0] tx_downstream_data;
    logic              tx_stb_userbit;
    logic [0:0]        tx_mrk_userbit;
    logic              tx_data_active;

    // Logic-link / control side that drives the generator.
    modport master (
        output tx_online, in_data, in_valid, tx_downstream_pop_ovrd,
        input  in_ready, tx_downstream_data, tx_stb_userbit, tx_mrk_userbit, tx_data_active
    );

    // The generator itself.
    modport slave (
        input  tx_online, in_data, in_valid, tx_downstream_pop_ovrd,
        output in_ready, tx_downstream_data, tx_stb_userbit, tx_mrk_userbit, tx_data_active
    );
endinterface

// File: rtl/lpif_tx_sync_fifo.sv
// Single-clock FIFO with synchronous flush and occupancy count.
// Latency: read data is combinational from the head entry; push visible next cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush wins over both.
module lpif_tx_sync_fifo #(
    parameter int WIDTH = 75,
    parameter int DEPTH = 4
) (
    input  logic                     clk_wr,
    input  logic                     rst_wr_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Storage write; no reset needed since count gates every read.
    always_ff @(posedge clk_wr) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/lpif_tx_x2_stb_mrk_gen.sv
// LPIF TX: buffers logic-link beats, generates strobe/marker user bits, streams once aligned.
// Latency: 2 cycles minimum from in_data accept to tx_downstream_data (no empty-FIFO bypass).
// Backpressure: in_ready drops when FIFO is full or link offline; pop_ovrd stalls the drain.
// Build option LPIF_TX_IDLE_REPEAT_EN: hold last popped data on idle beats instead of zero.
module lpif_tx_x2_stb_mrk_gen
    import lpif_tx_stb_mrk_pkg::*;
#(
    parameter int DWIDTH       = LPIF_DWIDTH_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int STB_INTERVAL = 16
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr_n,
    lpif_tx_x2_stb_mrk_gen_if.slave   bus
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SCW = (STB_INTERVAL > 2) ? $clog2(STB_INTERVAL) : 1;
    localparam logic [SCW-1:0] STB_LAST = SCW'(STB_INTERVAL - 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [SCW-1:0]    stb_cnt;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_rd_data;
    logic              push;
    logic              pop;
    logic              flush;
    logic              ready;
    logic              stb;
    logic              mrk;
    logic [DWIDTH-1:0] out_data;
    logic              out_active;

    lpif_tx_sync_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_wr   (clk_wr),
        .rst_wr_n (rst_wr_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_data  (bus.in_data),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // State register.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next state plus handshake/user-bit decode; dropping online overrides everything.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        stb       = 1'b0;
        mrk       = 1'b0;
        flush     = !bus.tx_online;
        push      = 1'b0;
        pop       = 1'b0;

        if (!bus.tx_online) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ALIGN;
                ALIGN:   if (stb_cnt == STB_LAST) state_nxt = ACTIVE;
                ACTIVE:  state_nxt = ACTIVE;
                default: state_nxt = IDLE;
            endcase
        end

        if (state != IDLE) begin
            mrk   = 1'b1;
            stb   = (stb_cnt == STB_LAST);
            ready = (fifo_count < DEPTH_C);
        end

        // Full cannot coincide with ready; the extra term keeps the FIFO safe if ready is ever relaxed.
        push = bus.in_valid && ready && !fifo_full;
        pop  = (state == ACTIVE) && bus.tx_online && !fifo_empty && !bus.tx_downstream_pop_ovrd;
    end

    // Strobe period counter: frozen at zero while idle or going idle, wraps after each strobe.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            stb_cnt <= '0;
        end else if (state == IDLE || state_nxt == IDLE) begin
            stb_cnt <= '0;
        end else if (stb_cnt == STB_LAST) begin
            stb_cnt <= '0;
        end else begin
            stb_cnt <= stb_cnt + SCW'(1);
        end
    end

    // Output beat register: one cycle after the pop; idle beats zero or hold per build option.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            out_data   <= '0;
            out_active <= 1'b0;
        end else begin
            out_active <= pop;
            if (pop) begin
                out_data <= fifo_rd_data;
            end else begin
`ifdef LPIF_TX_IDLE_REPEAT_EN
                if (state_nxt == IDLE) out_data <= '0;
`else
                out_data <= '0;
`endif
            end
        end
    end

    assign bus.in_ready           = ready;
    assign bus.tx_stb_userbit     = stb;
    assign bus.tx_mrk_userbit     = mrk;
    assign bus.tx_downstream_data = out_data;
    assign bus.tx_data_active     = out_active;
endmodule

// File: tb/tb_lpif_tx_x2_stb_mrk_gen.sv
// Bench for lpif_tx_x2_stb_mrk_gen: directed stimulus with a decoupled scoreboard monitor.
// Latency: beats tagged with an expected output cycle are checked for exact timing.
// Backpressure: exercises pop_ovrd stalls, FIFO full, offline flush and mid-stream reset.
module tb_lpif_tx_x2_stb_mrk_gen;
    localparam int DW = 75;

    logic clk_wr   = 1'b0;
    logic rst_wr_n = 1'b0;

    always #5 clk_wr = ~clk_wr;

    lpif_tx_x2_stb_mrk_gen_if #(.DWIDTH(DW)) bus ();

    lpif_tx_x2_stb_mrk_gen #(
        .DWIDTH       (DW),
        .FIFO_DEPTH   (4),
        .STB_INTERVAL (16)
    ) dut (
        .clk_wr   (clk_wr),
        .rst_wr_n (rst_wr_n),
        .bus      (bus)
    );

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc_at;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk_wr) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Scoreboard monitor: every output beat is matched against the queue.
    initial begin
        exp_t          e;
        logic [DW-1:0] last_dat;
        last_dat = '0;
        forever begin
            @(negedge clk_wr);
            if (bus.tx_mrk_userbit === 1'b0) last_dat = '0;
            if (bus.tx_data_active === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_beat: got data %0h with nothing expected", bus.tx_downstream_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", bus.tx_downstream_data, e.dat);
                    if (e.cyc_at >= 0) chk("beat_latency", cyc, e.cyc_at);
                    last_dat = e.dat;
                end
            end else begin
`ifdef LPIF_TX_IDLE_REPEAT_EN
                chk("idle_hold", bus.tx_downstream_data, last_dat);
`else
                chk("idle_zero", bus.tx_downstream_data, '0);
`endif
            end
        end
    end

    // Present one beat and keep it asserted until accepted; expected cycle is push + 2.
    task automatic send(input logic [DW-1:0] d, input bit timed, input bit record);
        int   g;
        exp_t e;
        g = 0;
        @(negedge clk_wr);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && g < 200) begin
            @(negedge clk_wr);
            g++;
        end
        if (g >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready stayed %b want 1", bus.in_ready);
        end else if (record) begin
            e.dat    = d;
            e.cyc_at = timed ? cyc + 2 : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_in();
        @(negedge clk_wr);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk_wr);
            g++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats left want 0", exp_q.size());
        end
        @(negedge clk_wr);
    endtask

    initial begin
        bus.tx_online              = 1'b0;
        bus.in_valid               = 1'b0;
        bus.in_data                = '0;
        bus.tx_downstream_pop_ovrd = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk_wr);
        chk("rst_ready",  bus.in_ready, 0);
        chk("rst_stb",    bus.tx_stb_userbit, 0);
        chk("rst_mrk",    bus.tx_mrk_userbit, 0);
        chk("rst_active", bus.tx_data_active, 0);
        chk("rst_data",   bus.tx_downstream_data, 0);
        rst_wr_n = 1'b1;

        @(negedge clk_wr);
        chk("idle_ready", bus.in_ready, 0);
        bus.tx_online = 1'b1;  // cycle 0

        // Marker from cycle 1, strobes at cycles 16 and 32 only.
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk_wr);
            chk("stb_at_cycle", bus.tx_stb_userbit, (c == 16 || c == 32));
            chk("mrk_online",   bus.tx_mrk_userbit, 1);
            if (c == 1) chk("align_ready", bus.in_ready, 1);
        end

        // Back-to-back pushes, each out exactly two cycles later.
        send(75'h1, 1'b1, 1'b1);
        send(75'h2, 1'b1, 1'b1);
        send(75'h3, 1'b1, 1'b1);
        idle_in();
        wait_drain();

        // Stalled drain: four fill the FIFO, fifth waits for ready.
        bus.tx_downstream_pop_ovrd = 1'b1;
        for (int k = 0; k < 4; k++) send(75'h11 + k, 1'b0, 1'b1);
        @(negedge clk_wr);
        bus.in_data = 75'h15;
        for (int k = 0; k < 3; k++) begin
            chk("ready_full", bus.in_ready, 0);
            @(negedge clk_wr);
        end
        bus.tx_downstream_pop_ovrd = 1'b0;
        send(75'h15, 1'b0, 1'b1);
        idle_in();
        wait_drain();

        // Single beat, then idle beats follow the build option.
        send(75'h5A, 1'b1, 1'b1);
        idle_in();
        wait_drain();
        repeat (3) @(negedge clk_wr);

        // Offline with three buffered beats: flushed, nothing stale afterwards.
        bus.tx_downstream_pop_ovrd = 1'b1;
        send(75'h21, 1'b0, 1'b0);
        send(75'h22, 1'b0, 1'b0);
        send(75'h23, 1'b0, 1'b0);
        @(negedge clk_wr);
        bus.in_valid  = 1'b0;
        bus.tx_online = 1'b0;
        @(negedge clk_wr);
        chk("offline_mrk",   bus.tx_mrk_userbit, 0);
        chk("offline_stb",   bus.tx_stb_userbit, 0);
        chk("offline_ready", bus.in_ready, 0);
        @(negedge clk_wr);
        bus.tx_online              = 1'b1;
        bus.tx_downstream_pop_ovrd = 1'b0;
        for (int k = 0; k < 4; k++) send(75'h31 + k, 1'b0, 1'b1);
        idle_in();
        chk("ready_count_after_flush", bus.in_ready, 0);
        wait_drain();

        // Reset mid-stream with two beats buffered.
        bus.tx_downstream_pop_ovrd = 1'b1;
        send(75'h41, 1'b0, 1'b0);
        send(75'h42, 1'b0, 1'b0);
        idle_in();
        #2 rst_wr_n = 1'b0;
        #1;
        chk("midrst_ready",  bus.in_ready, 0);
        chk("midrst_mrk",    bus.tx_mrk_userbit, 0);
        chk("midrst_stb",    bus.tx_stb_userbit, 0);
        chk("midrst_active", bus.tx_data_active, 0);
        chk("midrst_data",   bus.tx_downstream_data, 0);
        @(negedge clk_wr);
        rst_wr_n                   = 1'b1;
        bus.tx_downstream_pop_ovrd = 1'b0;
        repeat (25) @(negedge clk_wr);
        chk("post_rst_mrk", bus.tx_mrk_userbit, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
